// File: rtl/instr_fetch_unit_if.sv
// Interface bundling the fetch unit's memory port, core handshake and status.
//   master : fetch unit side (drives memory address/strobe and core in/load/s)
//   slave  : environment side (instruction memory, core, run control)
// Parameter ADDR_W must match the ADDR_W of the attached instr_fetch_unit.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              run;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_rdata;
  logic [15:0]       cpu_in;
  logic              cpu_load;
  logic              cpu_s;
  logic              cpu_w;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       instr_count;
  logic              halted;

  modport master (
    input  run, mem_rdata, cpu_w,
    output mem_addr, mem_rd, cpu_in, cpu_load, cpu_s, pc, instr_count, halted
  );

  modport slave (
    output run, mem_rdata, cpu_w,
    input  mem_addr, mem_rd, cpu_in, cpu_load, cpu_s, pc, instr_count, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer feeding the cpu core.
// Reads a 16-bit word at pc from a synchronous memory (data one cycle after
// mem_rd), latches it onto cpu_in, pulses cpu_load then cpu_s, waits for the
// core to finish via cpu_w, then advances pc and the saturating instr_count.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : instr_fetch_unit_if.master (run, mem_*, cpu_*, pc, instr_count, halted)
// Optional feature: define IFU_HALT_DETECT_EN to stop in HALTED on any fetched
// word with opcode bits [15:13] == 3'b111 (latched but never issued).
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StMemWait, StLoad, StStart, StBusy, StDone, StHalted
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       instr_q, instr_d;
  logic [1:0]        busy_cnt_q, busy_cnt_d;
  logic              halt_op;

`ifdef IFU_HALT_DETECT_EN
  assign halt_op    = (bus.mem_rdata[15:13] == 3'b111);
  assign bus.halted = (state_q == StHalted);
`else
  assign halt_op    = 1'b0;
  assign bus.halted = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      count_q    <= 16'h0000;
      instr_q    <= 16'h0000;
      busy_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    instr_d    = instr_q;
    busy_cnt_d = busy_cnt_q;
    unique case (state_q)
      StIdle:    if (bus.run && bus.cpu_w) state_d = StFetch;
      StFetch:   state_d = StMemWait;
      StMemWait: begin
        instr_d = bus.mem_rdata;
        state_d = halt_op ? StHalted : StLoad;
      end
      StLoad:    state_d = StStart;
      StStart: begin
        busy_cnt_d = 2'd0;
        state_d    = StBusy;
      end
      StBusy: begin
        // A core that never drops w is assumed to have run a one-cycle
        // instruction; give up waiting after 4 idle cycles.
        if (!bus.cpu_w || busy_cnt_q == 2'd3) state_d = StDone;
        else busy_cnt_d = busy_cnt_q + 2'd1;
      end
      StDone: begin
        if (bus.cpu_w) begin
          pc_d    = pc_q + ADDR_W'(1);
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          state_d = bus.run ? StFetch : StIdle;
        end
      end
      StHalted:  state_d = StHalted;
    endcase
  end

  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.mem_rd      = (state_q == StFetch);
  assign bus.cpu_load    = (state_q == StLoad);
  assign bus.cpu_s       = (state_q == StStart);
  assign bus.cpu_in      = instr_q;
  assign bus.instr_count = count_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer placed directly upstream of the `cpu` core. It reads 16-bit instructions from a synchronous instruction memory at the program counter. It presents each word to the core through the core's `in`/`load` inputs, pulses `s`, and waits on the core's `w` handshake before advancing the PC. The block replaces the manual switch/button loading used in bench bring-up.

## Interface
Parameters:
- `ADDR_W`, default 8: program counter and memory address width.
- `RESET_PC`, default 0: PC value after reset.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high.
- `run`  input  1  level; fetching is permitted while high.
- `mem_addr`  output  ADDR_W  instruction memory address; always equals `pc`.
- `mem_rd`  output  1  memory read strobe.
- `mem_rdata`  input  16  memory read data; valid the cycle after `mem_rd`.
- `cpu_in`  output  16  latched instruction word; drives the core's `in`.
- `cpu_load`  output  1  one-cycle pulse; drives the core's `load`.
- `cpu_s`  output  1  one-cycle start pulse; drives the core's `s`.
- `cpu_w`  input  1  the core's wait flag; high means the core is idle.
- `pc`  output  ADDR_W  current program counter.
- `instr_count`  output  16  count of completed instructions; saturating.
- `halted`  output  1  high in the HALTED state.

## Operation
States: IDLE, FETCH, MEMWAIT, LOAD, START, BUSY, DONE, HALTED.

- IDLE: leaves to FETCH when `run`=1 and `cpu_w`=1. Otherwise stays in IDLE.
- FETCH: drives `mem_rd`=1 with `mem_addr`=`pc`. Next state is MEMWAIT.
- MEMWAIT: captures `mem_rdata` into the instruction latch (`cpu_in`) at the end of the cycle. Next state is LOAD.
- LOAD: drives `cpu_load`=1. Next state is START.
- START: drives `cpu_s`=1. Next state is BUSY.
- BUSY: waits for `cpu_w`=0. If `cpu_w` stays 1 for 4 consecutive cycles, the core is treated as having completed a single-cycle instruction, and the state moves to DONE.
- DONE: waits for `cpu_w`=1.
  - On that cycle, `pc` becomes `pc`+1, modulo 2^ADDR_W, so all-ones wraps to 0.
  - On that cycle, `instr_count` increments and holds at 16'hFFFF.
  - Next state is FETCH if `run`=1, else IDLE.
- HALTED: entered only when the configuration below is enabled. The state is terminal until `reset`.

Rules:
- `mem_rd`, `cpu_load` and `cpu_s` are Moore outputs. Each is high only in its named state and is never high together with either of the others.
- Deasserting `run` mid-instruction does not abort the instruction. The current instruction completes, and the FSM returns to IDLE after DONE.
- `cpu_in` changes only at the end of MEMWAIT, and it is held stable through LOAD, START, BUSY and DONE.
- `reset` asserted in any state immediately forces every reset value. An in-flight instruction is discarded.

## Timing
Reset values:
- State is IDLE.
- `pc`=`mem_addr`=RESET_PC.
- `cpu_in`=16'h0000.
- `mem_rd`=`cpu_load`=`cpu_s`=0.
- `instr_count`=0.
- `halted`=0.

Latency from IDLE to the first `cpu_s` pulse is 4 cycles (IDLE→FETCH→MEMWAIT→LOAD→START), with `cpu_s` high in the 4th cycle after leaving IDLE.

Back-to-back throughput: 5 cycles of fetch overhead plus the core's busy time. The first FETCH of the next instruction follows the DONE cycle in which `cpu_w` returned to 1.

## Configuration
Macro: `IFU_HALT_DETECT_EN`.

- Defined:
  - In MEMWAIT, if `mem_rdata[15:13]`=3'b111, the word is latched into `cpu_in` and the FSM goes to HALTED instead of LOAD.
  - `halted`=1.
  - `cpu_load`/`cpu_s` are never pulsed for that word.
  - `pc` is not incremented and `instr_count` is unchanged.
- Undefined:
  - HALTED is unreachable and `halted` is tied to 0.
  - Opcode 111 is fetched and issued like any other word.

## Test plan
- Reset with RESET_PC=0 and mem[0]=16'hD105 (MOV R1,#5), `run`=1, core model returning `w` after 3 busy cycles → `mem_rd` in cycle 1, `cpu_in`=16'hD105 with `cpu_load` in cycle 3, `cpu_s` in cycle 4; after `w` rises, `pc`=1 and `instr_count`=1.
- Three consecutive instructions at mem[0..2] → `pc` reaches 3, `instr_count`=3, and no strobe overlap throughout.
- `run` dropped while in BUSY → the instruction completes, `pc` increments once, and the FSM sits in IDLE with all strobes low.
- ADDR_W=2, `pc`=3, instruction completes → `pc`=0 and `mem_addr`=0.
- `IFU_HALT_DETECT_EN` defined, mem[1]=16'hE000 → after the first instruction, `halted`=1, `pc` stays 1, `cpu_s` is never pulsed again; `reset` then clears `halted` and sets `pc`=0.
- `reset` pulsed during START → `cpu_s`=0 immediately, `pc`=RESET_PC, `cpu_in`=0, state IDLE.
